common_fifo_ram_1w1r_rdstage: RTL and testbench

Read-side output stage placed directly downstream of the 1-write/1-read RAM FIFO. It pops words from the FIFO's asynchronous-read head (dout, fifo_empty, ren) into a 2-entry registered buffer, and presents them on a valid/ready stream. fifo_ren depends only on registered state, fifo_empty and flush, never on m_ready. This breaks the combinational ready-to-RAM-pointer path while sustaining one word per cycle.

---
 rtl/common_fifo_ram_1w1r_rdstage_if.sv | 11 +
 rtl/common_fifo_ram_1w1r_rdstage.sv | 84 ++++++++
 tb/tb_common_fifo_ram_1w1r_rdstage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/common_fifo_ram_1w1r_rdstage_if.sv
// Valid/ready word stream leaving the FIFO read stage.
interface common_fifo_ram_1w1r_rdstage_if #(
    parameter int unsigned WIDTH = 1
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/common_fifo_ram_1w1r_rdstage.sv
// Registered 2-entry read stage for the 1W1R RAM FIFO: pops the async-read head
// and presents it on a valid/ready stream without a ready-to-pointer comb path.
module common_fifo_ram_1w1r_rdstage #(
    parameter int unsigned FIFO_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    input  logic                  flush,
    common_fifo_ram_1w1r_rdstage_if.master m,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        S0    = 2'd0,
        S1    = 2'd1,
        S2    = 2'd2,
        S_BAD = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [FIFO_WIDTH-1:0] e0, e1, e0_nxt, e1_nxt;
    logic                  drain;
    logic                  pop;

    // Pop decision uses only registered state, so m.ready never reaches the FIFO pointers.
    assign fifo_ren  = reset & ~flush & ~fifo_empty & ((state == S0) | (state == S1));
    assign pop       = fifo_ren;
    assign m.valid   = (state == S1) | (state == S2);
    assign m.data    = e0;
    assign drain     = m.valid & m.ready;
    assign occupancy = 2'(state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            state <= state_nxt;
            e0    <= e0_nxt;
            e1    <= e1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        e0_nxt    = e0;
        e1_nxt    = e1;
        if (flush) begin
            // Buffer contents are abandoned; e0 is left alone so m.data does not glitch.
            state_nxt = S0;
        end else begin
            unique case (state)
                S0: begin
                    if (pop) begin
                        state_nxt = S1;
                        e0_nxt    = fifo_dout;
                    end
                end
                S1: begin
                    if (pop && drain) begin
                        e0_nxt = fifo_dout;
                    end else if (pop) begin
                        state_nxt = S2;
                        e1_nxt    = fifo_dout;
                    end else if (drain) begin
                        state_nxt = S0;
                    end
                end
                S2: begin
                    if (drain) begin
                        state_nxt = S1;
                        e0_nxt    = e1;
                    end
                end
                default: state_nxt = S0;
            endcase
        end
    end

endmodule

// File: tb/tb_common_fifo_ram_1w1r_rdstage.sv
// Directed bench for the FIFO read stage with a small array-based FIFO model.
module tb_common_fifo_ram_1w1r_rdstage;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         fifo_ren;
    logic         fifo_empty;
    logic [W-1:0] fifo_dout;
    logic [1:0]   occupancy;

    logic [W-1:0] mem [64];
    logic [5:0]   rd_ptr = '0;
    logic [5:0]   wr_ptr = '0;
    logic [W-1:0] rx [$];

    int nvec = 0;
    int nerr = 0;

    common_fifo_ram_1w1r_rdstage_if #(.WIDTH(W)) m_if ();

    common_fifo_ram_1w1r_rdstage #(.FIFO_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .flush      (flush),
        .m          (m_if.master),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr];

    always @(posedge clk or negedge reset) begin
        if (!reset)        rd_ptr <= '0;
        else if (fifo_ren) rd_ptr <= rd_ptr + 6'd1;
    end

    always @(posedge clk) begin
        if (reset && m_if.valid && m_if.ready) rx.push_back(m_if.data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        m_if.ready = 1'b0;
        wr_ptr = '0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        m_if.ready = 1'b1;
        push(8'hA1); push(8'hB2); push(8'hC3);
        repeat (2) @(negedge clk);

        // reset state with a non-empty FIFO
        chk("rst_valid", 32'(m_if.valid), 32'd0);
        chk("rst_occ",   32'(occupancy),  32'd0);
        chk("rst_ren",   32'(fifo_ren),   32'd1 - 32'd1);
        chk("rst_data",  32'(m_if.data),  32'h0);

        // streaming A,B,C with ready high
        reset = 1'b1;
        #1 chk("t1_ren_c0", 32'(fifo_ren), 32'd1);
        @(negedge clk);
        chk("t1_dA", 32'(m_if.data), 32'hA1); chk("t1_vA", 32'(m_if.valid), 32'd1);
        chk("t1_renA", 32'(fifo_ren), 32'd1);
        @(negedge clk);
        chk("t1_dB", 32'(m_if.data), 32'hB2); chk("t1_vB", 32'(m_if.valid), 32'd1);
        @(negedge clk);
        chk("t1_dC", 32'(m_if.data), 32'hC3); chk("t1_vC", 32'(m_if.valid), 32'd1);
        chk("t1_renC", 32'(fifo_ren), 32'd0);
        @(negedge clk);
        chk("t1_vend", 32'(m_if.valid), 32'd0);

        // backpressure: exactly two pops, then stable
        hold_reset();
        for (int i = 0; i < 5; i++) push(W'(8'h50 + i));
        release_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_occ",  32'(occupancy),  32'd2);
            chk("bp_ren",  32'(fifo_ren),   32'd0);
            chk("bp_data", 32'(m_if.data),  32'h50);
            chk("bp_rdp",  32'(rd_ptr),     32'd2);
            @(negedge clk);
        end
        m_if.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_seq",   32'(m_if.data),  32'h50 + 32'(i));
            chk("bp_seqv",  32'(m_if.valid), 32'd1);
            @(negedge clk);
        end
        chk("bp_vend", 32'(m_if.valid), 32'd0);
        chk("bp_rdp5", 32'(rd_ptr), 32'd5);

        // alternating ready with a continuously non-empty FIFO
        hold_reset();
        for (int i = 0; i < 20; i++) push(W'(8'h60 + i));
        release_reset();
        rx.delete();
        for (int i = 0; i < 16; i++) begin
            m_if.ready = ~i[0];
            #1;
            chk("alt_occ_le2", 32'(occupancy <= 2'd2), 32'd1);
            chk("alt_ren_s2",  32'(fifo_ren && occupancy == 2'd2), 32'd0);
            @(negedge clk);
        end
        m_if.ready = 1'b0;
        chk("alt_cnt", 32'(rx.size()), 32'd7);
        for (int k = 0; k < rx.size(); k++) chk("alt_order", 32'(rx[k]), 32'h60 + 32'(k));

        // flush while holding two words
        hold_reset();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        release_reset();
        repeat (2) @(negedge clk);
        chk("fl2_occ_pre", 32'(occupancy), 32'd2);
        chk("fl2_e1_pre",  32'(m_if.data), 32'h11);
        flush = 1'b1;
        #1 chk("fl2_ren", 32'(fifo_ren), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("fl2_occ",   32'(occupancy),  32'd0);
        chk("fl2_valid", 32'(m_if.valid), 32'd0);
        chk("fl2_rdp",   32'(rd_ptr),     32'd2);
        #1 chk("fl2_ren_after", 32'(fifo_ren), 32'd1);
        @(negedge clk);
        chk("fl2_next", 32'(m_if.data), 32'h33);
        chk("fl2_nextv", 32'(m_if.valid), 32'd1);

        // flush with a handshake in the same cycle
        rx.delete();
        m_if.ready = 1'b1;
        flush = 1'b1;
        #1 chk("fl1_ren", 32'(fifo_ren), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("fl1_valid", 32'(m_if.valid), 32'd0);
        chk("fl1_occ",   32'(occupancy),  32'd0);
        chk("fl1_rdp",   32'(rd_ptr),     32'd3);
        chk("fl1_hs_n",  32'(rx.size()),  32'd1);
        if (rx.size() > 0) chk("fl1_hs_d", 32'(rx[0]), 32'h33);
        @(negedge clk);
        chk("fl1_next", 32'(m_if.data), 32'h44);

        // asynchronous reset mid-stream
        hold_reset();
        for (int i = 0; i < 8; i++) push(W'(8'h70 + i));
        release_reset();
        m_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_pre", 32'(m_if.data), 32'h72);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 32'(m_if.valid), 32'd0);
        chk("ar_ren",   32'(fifo_ren),   32'd0);
        chk("ar_occ",   32'(occupancy),  32'd0);
        wr_ptr = '0;
        push(8'h80); push(8'h81);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("ar_ren_rel", 32'(fifo_ren), 32'd1);
        @(negedge clk);
        chk("ar_d0", 32'(m_if.data), 32'h80);
        @(negedge clk);
        chk("ar_d1", 32'(m_if.data), 32'h81);
        @(negedge clk);
        chk("ar_vend", 32'(m_if.valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
